mem_responder_dm: RTL and testbench

Direct-mapped, write-through cache responder serving the fetch and memory stages' `Addr/Rd/Wr/DataOut/Done/Stall/CacheHit/err` request interface. It sits between a pipeline stage and a fixed-protocol backing memory. Hits complete in the request cycle. Misses stall the requester while a 4-word line is filled word by word from the backing memory.

---
 rtl/mem_responder_pkg.sv | 10 +
 rtl/mem_line_array.sv | 38 +++
 rtl/mem_responder_dm.sv | 104 ++++++++++
 tb/tb_mem_responder_dm.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_responder_pkg.sv
// mem_responder_pkg: shared types and geometry for the direct-mapped cache responder.
package mem_responder_pkg;
    typedef enum logic [1:0] {IDLE, FILL, RESP, WRITE} state_t;
    localparam int WORDS_PER_LINE = 4;
    localparam int OFFSET_LSB = 1;
    localparam int INDEX_LSB = 3;
    function automatic int tag_bits(input int index_bits);
        return 16 - INDEX_LSB - index_bits;
    endfunction
endpackage

// File: rtl/mem_line_array.sv
// mem_line_array: valid/tag/data storage with async-read lookup and a synchronous write port.
module mem_line_array
    import mem_responder_pkg::*;
#(
    parameter int INDEX_BITS = 5,
    parameter int TAG_BITS = tag_bits(INDEX_BITS)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [INDEX_BITS-1:0] index,
    input  logic [1:0]            offset,
    output logic                  valid,
    output logic [TAG_BITS-1:0]   tag,
    output logic [15:0]           data,
    input  logic                  word_we,
    input  logic [1:0]            word_sel,
    input  logic [15:0]           word_data,
    input  logic                  tag_we,
    input  logic [TAG_BITS-1:0]   tag_data,
    input  logic                  valid_set,
    input  logic                  valid_clr
);
    localparam int LINES = 1 << INDEX_BITS;
    logic [LINES-1:0] valid_q;
    logic [TAG_BITS-1:0] tag_q [LINES];
    logic [15:0] data_q [LINES*WORDS_PER_LINE];
    assign valid = valid_q[index];
    assign tag = tag_q[index];
    assign data = data_q[{index, offset}];
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) valid_q <= '0;
        else if (valid_set) valid_q[index] <= 1'b1;
        else if (valid_clr) valid_q[index] <= 1'b0;
    always_ff @(posedge clk) begin
        if (tag_we) tag_q[index] <= tag_data;
        if (word_we) data_q[{index, word_sel}] <= word_data;
    end
endmodule

// File: rtl/mem_responder_dm.sv
// mem_responder_dm: direct-mapped write-through cache responder with word-by-word line fill.
// Define MEM_RESPONDER_STATS_EN to enable the saturating hit/miss counters.
module mem_responder_dm
    import mem_responder_pkg::*;
#(
    parameter int INDEX_BITS = 5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] Addr,
    input  logic [15:0] DataIn,
    input  logic        Rd,
    input  logic        Wr,
    output logic [15:0] DataOut,
    output logic        Done,
    output logic        Stall,
    output logic        CacheHit,
    output logic        err,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    output logic        mem_rd,
    output logic        mem_wr,
    input  logic [15:0] mem_rdata,
    input  logic        mem_ack,
    output logic [15:0] hit_cnt,
    output logic [15:0] miss_cnt
);
    localparam int TAG_BITS = tag_bits(INDEX_BITS);
    localparam int TAG_LSB = INDEX_LSB + INDEX_BITS;
    state_t state;
    logic [1:0] wc, offset;
    logic [INDEX_BITS-1:0] index;
    logic [TAG_BITS-1:0] tag, line_tag;
    logic [15:0] line_data;
    logic line_valid, hit, rd, wr, idle, bad, rd_hit, rd_miss, wr_go, fill_ack, wr_ack;
    assign offset = Addr[OFFSET_LSB+1:OFFSET_LSB];
    assign index = Addr[TAG_LSB-1:INDEX_LSB];
    assign tag = Addr[15:TAG_LSB];
    // Requests are masked while reset is held so every output reads as idle.
    assign rd = Rd & rst_n;
    assign wr = Wr & rst_n;
    assign idle = state == IDLE;
    assign hit = line_valid && line_tag == tag;
    assign bad = idle && ((rd && wr) || ((rd || wr) && Addr[0]));
    assign rd_hit = idle && rd && !bad && hit;
    assign rd_miss = idle && rd && !bad && !hit;
    assign wr_go = idle && wr && !bad;
    assign fill_ack = state == FILL && mem_ack;
    assign wr_ack = state == WRITE && mem_ack;
    assign err = bad;
    assign Done = bad || rd_hit || state == RESP || wr_ack;
    assign Stall = rd_miss || wr_go || state == FILL || (state == WRITE && !mem_ack);
    assign CacheHit = rd_hit || (wr_ack && hit);
    assign DataOut = (rd_hit || state == RESP) ? line_data : 16'h0000;
    assign mem_rd = state == FILL;
    assign mem_wr = state == WRITE;
    assign mem_addr = state == FILL ? {Addr[15:INDEX_LSB], wc, 1'b0} : Addr;
    assign mem_wdata = DataIn;
    mem_line_array #(.INDEX_BITS(INDEX_BITS), .TAG_BITS(TAG_BITS)) lines (
        .clk(clk),
        .rst_n(rst_n),
        .index(index),
        .offset(offset),
        .valid(line_valid),
        .tag(line_tag),
        .data(line_data),
        .word_we(fill_ack || (wr_ack && hit)),
        .word_sel(state == FILL ? wc : offset),
        .word_data(state == FILL ? mem_rdata : DataIn),
        .tag_we(rd_miss),
        .tag_data(tag),
        .valid_set(fill_ack && wc == 2'd3),
        .valid_clr(rd_miss)
    );
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state <= IDLE;
            wc <= 2'd0;
        end else case (state)
            IDLE: begin
                wc <= 2'd0;
                state <= rd_miss ? FILL : wr_go ? WRITE : IDLE;
            end
            FILL: if (mem_ack) begin
                wc <= wc + 2'd1;
                state <= wc == 2'd3 ? RESP : FILL;
            end
            RESP: state <= IDLE;
            WRITE: state <= mem_ack ? IDLE : WRITE;
        endcase
`ifdef MEM_RESPONDER_STATS_EN
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            hit_cnt <= 16'h0000;
            miss_cnt <= 16'h0000;
        end else begin
            if (Done && CacheHit && hit_cnt != 16'hFFFF) hit_cnt <= hit_cnt + 16'd1;
            if (Done && !CacheHit && !err && miss_cnt != 16'hFFFF) miss_cnt <= miss_cnt + 16'd1;
        end
`else
    assign hit_cnt = 16'h0000;
    assign miss_cnt = 16'h0000;
`endif
endmodule

// File: tb/tb_mem_responder_dm.sv
// tb_mem_responder_dm: vector table, reset-in-fill sequence and random traffic against a line-level model.
module tb_mem_responder_dm;
    logic clk = 0, rst_n = 0;
    logic [15:0] Addr = 0, DataIn = 0, mem_rdata = 0;
    logic Rd = 0, Wr = 0, mem_ack = 0;
    logic [15:0] DataOut, mem_addr, mem_wdata, hit_cnt, miss_cnt;
    logic Done, Stall, CacheHit, err, mem_rd, mem_wr;
    int checks = 0, errors = 0, ack_dly = 0;
    logic [15:0] bmem [32768];
    logic [15:0] ref_mem [32768];
    logic mvalid [32];
    logic [7:0] mtag [32];
    int mh, mm;
    int r_lat, r_nrd, r_nwr, r_proto, r_badf;
    logic r_err, r_hit;
    logic [15:0] r_dout;

    always #5 clk = ~clk;

    mem_responder_dm #(.INDEX_BITS(5)) dut (
        .clk(clk), .rst_n(rst_n), .Addr(Addr), .DataIn(DataIn), .Rd(Rd), .Wr(Wr),
        .DataOut(DataOut), .Done(Done), .Stall(Stall), .CacheHit(CacheHit), .err(err),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rd(mem_rd), .mem_wr(mem_wr),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
    );

    // Backing memory: acks after ack_dly idle cycles of a held request.
    initial begin
        int wcnt;
        wcnt = 0;
        for (int i = 0; i < 32768; i++) bmem[i] = 16'(i) ^ 16'hA008;
        forever begin
            @(posedge clk); #1;
            if (mem_ack) begin mem_ack = 0; wcnt = 0; end
            if (mem_rd || mem_wr) begin
                if (wcnt == ack_dly) begin
                    mem_ack = 1;
                    if (mem_rd) mem_rdata = bmem[mem_addr[15:1]];
                    else bmem[mem_addr[15:1]] = mem_wdata;
                end else wcnt++;
            end else wcnt = 0;
        end
    end

    task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", n, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) mvalid[i] = 0;
        mh = 0;
        mm = 0;
    endtask

    task automatic model(input logic r, input logic w, input logic [15:0] a, input logic [15:0] d,
                         input int ackd, output logic e_err, output logic e_hit, output int e_lat,
                         output int e_nrd, output int e_nwr, output logic [15:0] e_dout);
        int idx;
        logic h;
        idx = int'(a[7:3]);
        h = mvalid[idx] && mtag[idx] == a[15:8];
        e_err = (r && w) || a[0];
        e_hit = 0; e_lat = 0; e_nrd = 0; e_nwr = 0;
        e_dout = ref_mem[a[15:1]];
        if (!e_err && r) begin
            e_hit = h;
            if (!h) begin
                e_lat = 1 + 4 * (ackd + 1);
                e_nrd = 4 * (ackd + 1);
                mvalid[idx] = 1;
                mtag[idx] = a[15:8];
            end
        end else if (!e_err) begin
            e_hit = h;
            e_lat = 1 + ackd;
            e_nwr = ackd + 1;
            ref_mem[a[15:1]] = d;
        end
        if (!e_err) begin
            if (e_hit) mh++;
            else mm++;
        end
    endtask

    task automatic txn(input logic r, input logic w, input logic [15:0] a, input logic [15:0] d, input int ackd);
        int k;
        k = 0;
        ack_dly = ackd;
        Rd = r; Wr = w; Addr = a; DataIn = d;
        r_lat = -1; r_nrd = 0; r_nwr = 0; r_proto = 0; r_badf = 0;
        r_err = 0; r_hit = 0; r_dout = 0;
        for (int c = 0; c < 64 && r_lat < 0; c++) begin
            @(negedge clk);
            if (mem_rd) r_nrd++;
            if (mem_wr) r_nwr++;
            if (mem_rd && mem_wr) r_proto++;
            if (mem_rd && mem_ack) begin
                if (mem_addr !== ((a & 16'hFFF8) | 16'(2 * k))) r_badf++;
                k++;
            end
            if (Done) begin
                r_lat = c; r_err = err; r_hit = CacheHit; r_dout = DataOut;
                if (Stall) r_proto++;
            end else if (!Stall) r_proto++;
            @(posedge clk); #2;
        end
        Rd = 0; Wr = 0;
    endtask

    task automatic chk_txn(input string n, input logic e_err, input logic e_hit, input int e_lat,
                           input int e_nrd, input int e_nwr, input logic [15:0] e_dout, input logic cd);
        chk({n, ".lat"}, r_lat, e_lat);
        chk({n, ".err"}, {31'b0, r_err}, {31'b0, e_err});
        chk({n, ".hit"}, {31'b0, r_hit}, {31'b0, e_hit});
        if (cd) chk({n, ".dout"}, {16'b0, r_dout}, {16'b0, e_dout});
        chk({n, ".nrd"}, r_nrd, e_nrd);
        chk({n, ".nwr"}, r_nwr, e_nwr);
        chk({n, ".proto"}, r_proto, 0);
        chk({n, ".fetch"}, r_badf, 0);
    endtask

    task automatic chk_counters(input string n);
`ifdef MEM_RESPONDER_STATS_EN
        chk({n, ".hit_cnt"}, {16'b0, hit_cnt}, mh);
        chk({n, ".miss_cnt"}, {16'b0, miss_cnt}, mm);
`else
        chk({n, ".hit_cnt"}, {16'b0, hit_cnt}, 0);
        chk({n, ".miss_cnt"}, {16'b0, miss_cnt}, 0);
`endif
    endtask

    typedef struct {
        logic r, w;
        logic [15:0] a, d;
        int ackd;
        logic e_err, e_hit;
        int e_lat, e_nrd, e_nwr;
        logic [15:0] e_dout;
    } vec_t;

    initial begin
        vec_t tv [15];
        logic e_err, e_hit;
        int e_lat, e_nrd, e_nwr;
        logic [15:0] e_dout;
        tv[0]  = '{1'b1, 1'b0, 16'h0010, 16'h0000, 0, 1'b0, 1'b0, 5, 4, 0, 16'hA000};
        tv[1]  = '{1'b1, 1'b0, 16'h0012, 16'h0000, 0, 1'b0, 1'b1, 0, 0, 0, 16'hA001};
        tv[2]  = '{1'b0, 1'b1, 16'h0012, 16'h5555, 2, 1'b0, 1'b1, 3, 0, 3, 16'h0000};
        tv[3]  = '{1'b1, 1'b0, 16'h0012, 16'h0000, 0, 1'b0, 1'b1, 0, 0, 0, 16'h5555};
        tv[4]  = '{1'b1, 1'b0, 16'h0110, 16'h0000, 0, 1'b0, 1'b0, 5, 4, 0, 16'hA080};
        tv[5]  = '{1'b1, 1'b0, 16'h0010, 16'h0000, 0, 1'b0, 1'b0, 5, 4, 0, 16'hA000};
        tv[6]  = '{1'b1, 1'b1, 16'h0010, 16'h0000, 0, 1'b1, 1'b0, 0, 0, 0, 16'h0000};
        tv[7]  = '{1'b1, 1'b0, 16'h0011, 16'h0000, 0, 1'b1, 1'b0, 0, 0, 0, 16'h0000};
        tv[8]  = '{1'b0, 1'b1, 16'h0011, 16'h7777, 0, 1'b1, 1'b0, 0, 0, 0, 16'h0000};
        tv[9]  = '{1'b0, 1'b1, 16'h0200, 16'h1234, 0, 1'b0, 1'b0, 1, 0, 1, 16'h0000};
        tv[10] = '{1'b1, 1'b0, 16'h0200, 16'h0000, 0, 1'b0, 1'b0, 5, 4, 0, 16'h1234};
        tv[11] = '{1'b1, 1'b0, 16'h0016, 16'h0000, 0, 1'b0, 1'b1, 0, 0, 0, 16'hA003};
        tv[12] = '{1'b1, 1'b0, 16'h0012, 16'h0000, 0, 1'b0, 1'b1, 0, 0, 0, 16'h5555};
        tv[13] = '{1'b0, 1'b1, 16'h0014, 16'hBEEF, 1, 1'b0, 1'b1, 2, 0, 2, 16'h0000};
        tv[14] = '{1'b1, 1'b0, 16'h0014, 16'h0000, 0, 1'b0, 1'b1, 0, 0, 0, 16'hBEEF};
        for (int i = 0; i < 32768; i++) ref_mem[i] = 16'(i) ^ 16'hA008;
        model_reset();

        repeat (2) @(negedge clk);
        chk("reset.done", {31'b0, Done}, 0);
        chk("reset.stall", {31'b0, Stall}, 0);
        chk("reset.err", {31'b0, err}, 0);
        chk("reset.hit", {31'b0, CacheHit}, 0);
        chk("reset.dout", {16'b0, DataOut}, 0);
        chk("reset.mem_rd", {31'b0, mem_rd}, 0);
        chk("reset.mem_wr", {31'b0, mem_wr}, 0);
        chk("reset.hit_cnt", {16'b0, hit_cnt}, 0);
        chk("reset.miss_cnt", {16'b0, miss_cnt}, 0);
        @(posedge clk); #2;
        rst_n = 1;

        for (int i = 0; i < 15; i++) begin
            model(tv[i].r, tv[i].w, tv[i].a, tv[i].d, tv[i].ackd, e_err, e_hit, e_lat, e_nrd, e_nwr, e_dout);
            txn(tv[i].r, tv[i].w, tv[i].a, tv[i].d, tv[i].ackd);
            chk_txn($sformatf("vec%0d", i), tv[i].e_err, tv[i].e_hit, tv[i].e_lat, tv[i].e_nrd,
                    tv[i].e_nwr, tv[i].e_dout, tv[i].r && !tv[i].e_err);
        end
        chk_counters("table");

        // Reset lands after the second word of a fill has been acknowledged.
        ack_dly = 0;
        Rd = 1; Addr = 16'h0040;
        repeat (3) begin @(posedge clk); #2; end
        chk("midfill.mem_rd_before", {31'b0, mem_rd}, 1);
        rst_n = 0;
        #1;
        chk("midfill.mem_rd_drop", {31'b0, mem_rd}, 0);
        chk("midfill.stall", {31'b0, Stall}, 0);
        chk("midfill.done", {31'b0, Done}, 0);
        Rd = 0; Addr = 0;
        model_reset();
        @(posedge clk); #2;
        chk("midfill.hit_cnt", {16'b0, hit_cnt}, 0);
        chk("midfill.miss_cnt", {16'b0, miss_cnt}, 0);
        rst_n = 1;
        model(1'b1, 1'b0, 16'h0040, 16'h0000, 0, e_err, e_hit, e_lat, e_nrd, e_nwr, e_dout);
        txn(1'b1, 1'b0, 16'h0040, 16'h0000, 0);
        chk_txn("refetch", e_err, e_hit, e_lat, e_nrd, e_nwr, e_dout, 1'b1);
        chk("refetch.dout_abs", {16'b0, r_dout}, 32'h0000A028);

        for (int i = 0; i < 200; i++) begin
            logic r, w;
            logic [15:0] a, d;
            int k, ackd;
            k = $urandom_range(0, 19);
            r = k < 11 || k == 19;
            w = k >= 11;
            a = {8'($urandom_range(0, 2)), 5'($urandom_range(0, 7)), 2'($urandom_range(0, 3)),
                 1'($urandom_range(0, 15) == 0)};
            d = 16'($urandom);
            ackd = $urandom_range(0, 2);
            model(r, w, a, d, ackd, e_err, e_hit, e_lat, e_nrd, e_nwr, e_dout);
            txn(r, w, a, d, ackd);
            chk_txn($sformatf("rnd%0d", i), e_err, e_hit, e_lat, e_nrd, e_nwr, e_dout, r && !w && !e_err);
        end
        chk_counters("random");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
